uart_tx_scheduler: RTL and testbench

Byte-queue front end that sequences UART_Tx. Requesters push bytes over a valid/ready port into a DEPTH-entry FIFO. The scheduler presents each byte on tx_data, pulses tx_val, tracks UART_Tx busy through rise and fall, and inserts an inter-byte gap. It replaces hand-sequenced tx_val/busy handshaking. Its tx_val output also drives baudgen's tx_val.

---
 rtl/uart_tx_scheduler.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Byte FIFO plus transmit sequencer for UART_Tx. It pops one byte, strobes tx_val,
// follows busy through its rise and fall, then enforces an idle gap before the next byte.
module uart_tx_scheduler #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AW            = 4,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned BUSY_TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic          busy,
    output logic          tx_val,
    output logic [7:0]    tx_data,
    output logic [AW:0]   level,
    output logic          idle,
    output logic          sent_pulse,
    output logic          timeout_err,
    input  logic          clr_err
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    // Where a finished or abandoned byte goes next; skips GAP entirely when no gap is configured.
    localparam state_e POST_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_e          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic [7:0]      tx_data_q;
    logic            tx_val_q;
    logic            sent_pulse_q;
    logic            timeout_err_q;
    logic            busy_seen_q;
    logic [SW-1:0]   strb_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [TW-1:0]   timer_q;

    logic            push;
    logic            pop;

    assign wr_ready    = (level_q != LW'(DEPTH));
    assign push        = rst && wr_valid && wr_ready;
    assign pop         = (state_q == S_IDLE) && (level_q != '0) && !busy;

    assign level       = level_q;
    assign idle        = (state_q == S_IDLE) && (level_q == '0);
    assign tx_val      = tx_val_q;
    assign tx_data     = tx_data_q;
    assign sent_pulse  = sent_pulse_q;
    assign timeout_err = timeout_err_q;

    // Storage array carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            tx_data_q     <= 8'h00;
            tx_val_q      <= 1'b0;
            sent_pulse_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_seen_q   <= 1'b0;
            strb_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            timer_q       <= '0;
        end else begin
            sent_pulse_q <= 1'b0;
            if (clr_err) begin
                timeout_err_q <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_val_q    <= 1'b1;
                    timer_q     <= '0;
                    strb_cnt_q  <= '0;
                    busy_seen_q <= 1'b0;
                    state_q     <= S_STROBE;
                end
                S_STROBE: begin
                    timer_q <= timer_q + TW'(1);
                    if (busy) begin
                        busy_seen_q <= 1'b1;
                    end
                    if (strb_cnt_q + SW'(1) == SW'(STROBE_CYCLES)) begin
                        tx_val_q <= 1'b0;
                        state_q  <= S_WAIT_BUSY;
                    end else begin
                        strb_cnt_q <= strb_cnt_q + SW'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    timer_q <= timer_q + TW'(1);
                    if (busy_seen_q || busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q + TW'(1) == TW'(BUSY_TIMEOUT)) begin
                        // Set after the clear above so a simultaneous clr_err loses.
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= POST_STATE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        sent_pulse_q <= 1'b1;
                        gap_cnt_q    <= '0;
                        state_q      <= POST_STATE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q + GW'(1) == GW'(GAP_CYCLES)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART busy model.
module tb_uart_tx_scheduler;

    localparam int BUSY_LEN = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic        tx_val;
    logic [7:0]  tx_data;
    logic [4:0]  level;
    logic        idle;
    logic        sent_pulse;
    logic        timeout_err;
    logic        clr_err;

    logic        auto_busy;
    logic        busy_man;
    logic        busy_model = 1'b0;
    int          bcnt = 0;

    int          tests = 0;
    int          fails = 0;

    int          cyc = 0;
    int          sent_cnt = 0;
    int          rise_cnt = 0;
    int          fall_cyc = 0;
    logic        txv_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic [7:0]  cap_q[$];
    int          gap_q[$];

    always #5 clk = ~clk;

    assign busy = auto_busy ? busy_model : busy_man;

    uart_tx_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .tx_val      (tx_val),
        .tx_data     (tx_data),
        .level       (level),
        .idle        (idle),
        .sent_pulse  (sent_pulse),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    // UART_Tx stand-in: busy rises one cycle after tx_val and stays high BUSY_LEN cycles.
    always @(posedge clk) begin
        if (!auto_busy) begin
            busy_model <= 1'b0;
            bcnt       <= 0;
        end else if (tx_val && !busy_model) begin
            busy_model <= 1'b1;
            bcnt       <= BUSY_LEN - 1;
        end else if (busy_model) begin
            if (bcnt == 0) busy_model <= 1'b0;
            else           bcnt <= bcnt - 1;
        end
    end

    // Records each transmitted byte and its distance from the preceding busy fall.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_val && !txv_prev) begin
            rise_cnt <= rise_cnt + 1;
            cap_q.push_back(tx_data);
            gap_q.push_back(cyc - fall_cyc);
        end
        if (busy_prev && !busy) fall_cyc <= cyc;
        if (sent_pulse) sent_cnt <= sent_cnt + 1;
        txv_prev  <= tx_val;
        busy_prev <= busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] msg [13];
        int base_r;
        int base_s;
        int base_c;
        int n;
        int min_gap;

        msg = '{8'h4d, 8'h69, 8'h6b, 8'h72, 8'h6f, 8'h2d, 8'h54,
                8'h61, 8'h73, 8'h61, 8'h72, 8'h69, 8'h6d};

        // Reset with a write pending: nothing must be queued.
        rst = 1'b0; wr_valid = 1'b1; wr_data = 8'h55; clr_err = 1'b0;
        auto_busy = 1'b0; busy_man = 1'b0;
        repeat (3) step();
        wr_valid = 1'b0;
        rst = 1'b1;
        chk("rst_level", 32'(level), 0);
        chk("rst_tx_val", 32'(tx_val), 0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_sent", 32'(sent_pulse), 0);
        repeat (10) step();
        chk("rst_no_tx", 32'(rise_cnt), 0);

        // Single byte latency and handshake.
        base_r = rise_cnt; base_s = sent_cnt;
        auto_busy = 1'b1;
        wr_data = 8'h4d; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("t2_level_w", 32'(level), 1);
        chk("t2_data_pre", 32'(tx_data), 32'h00);
        step();
        chk("t2_data_e1", 32'(tx_data), 32'h4d);
        chk("t2_val_e1", 32'(tx_val), 0);
        chk("t2_level_pop", 32'(level), 0);
        step();
        chk("t2_val_e2", 32'(tx_val), 1);
        step();
        chk("t2_val_e3", 32'(tx_val), 0);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (sent_pulse) begin
                n = i;
                break;
            end
        end
        chk("t2_sent_lat", 32'(n), 101);
        chk("t2_busy_low", 32'(busy), 0);
        step();
        chk("t2_sent_1cyc", 32'(sent_pulse), 0);
        chk("t2_gap_busy", 32'(idle), 0);
        step();
        chk("t2_idle", 32'(idle), 1);
        chk("t2_sent_cnt", 32'(sent_cnt - base_s), 1);
        chk("t2_rise_cnt", 32'(rise_cnt - base_r), 1);

        // Burst of 13 bytes, order and inter-byte gap.
        base_s = sent_cnt; base_c = cap_q.size();
        for (int i = 0; i < 13; i++) begin
            wr_data = msg[i]; wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 3000 && (sent_cnt - base_s) < 13; i++) step();
        chk("t3_sent_cnt", 32'(sent_cnt - base_s), 13);
        chk("t3_cap_cnt", 32'(cap_q.size() - base_c), 13);
        if (cap_q.size() >= base_c + 13) begin
            min_gap = 1000000;
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("t3_byte%0d", i), 32'(cap_q[base_c + i]), 32'(msg[i]));
                if (i > 0 && gap_q[base_c + i] < min_gap) min_gap = gap_q[base_c + i];
            end
            chk("t3_min_gap_ge4", 32'(min_gap >= 4), 1);
        end
        for (int i = 0; i < 20 && !idle; i++) step();
        chk("t3_idle", 32'(idle), 1);

        // Timeout when busy never rises, then clear.
        auto_busy = 1'b0; busy_man = 1'b0;
        step();
        base_r = rise_cnt; base_s = sent_cnt;
        wr_data = 8'ha5; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        step();
        chk("t5_val", 32'(tx_val), 1);
        repeat (63) step();
        chk("t5_err_early", 32'(timeout_err), 0);
        step();
        chk("t5_err_set", 32'(timeout_err), 1);
        chk("t5_not_idle", 32'(idle), 0);
        step();
        step();
        chk("t5_idle", 32'(idle), 1);
        chk("t5_no_sent", 32'(sent_cnt - base_s), 0);
        chk("t5_one_rise", 32'(rise_cnt - base_r), 1);
        repeat (5) step();
        chk("t5_sticky", 32'(timeout_err), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t5_cleared", 32'(timeout_err), 0);

        // Full FIFO while busy held high.
        busy_man = 1'b1;
        base_r = rise_cnt;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h10 + i); wr_valid = 1'b1;
            step();
            if (i == 15) begin
                chk("t4_level_full", 32'(level), 16);
                chk("t4_ready_full", 32'(wr_ready), 0);
            end
        end
        wr_valid = 1'b0;
        chk("t4_level_17", 32'(level), 16);
        chk("t4_no_tx", 32'(rise_cnt - base_r), 0);
        auto_busy = 1'b1;
        step();
        chk("t4_pop1_level", 32'(level), 15);
        chk("t4_pop1_data", 32'(tx_data), 32'h10);
        for (int i = 0; i < 300 && level == 5'd15; i++) step();
        chk("t4_pop2_level", 32'(level), 14);
        chk("t4_pop2_data", 32'(tx_data), 32'h11);

        // Reset in the middle of a byte.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 300 && busy; i++) step();
        chk("t6_busy_low", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'ha1 + i); wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 50 && !busy; i++) step();
        chk("t6_busy_up", 32'(busy), 1);
        repeat (3) step();
        chk("t6_level_pre", 32'(level), 2);
        rst = 1'b0;
        step();
        base_r = rise_cnt; base_s = sent_cnt;
        chk("t6_level", 32'(level), 0);
        chk("t6_tx_val", 32'(tx_val), 0);
        chk("t6_sent", 32'(sent_pulse), 0);
        rst = 1'b1;
        repeat (300) step();
        chk("t6_no_sent", 32'(sent_cnt - base_s), 0);
        chk("t6_no_rise", 32'(rise_cnt - base_r), 0);
        chk("t6_idle", 32'(idle), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
